// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control unit and datapath:
// FSM state encodings, counter widths and the load-use hazard test.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_e;

    localparam int CNT_W   = 16;  // performance counters
    localparam int WAIT_W  = 8;   // memory-wait counter (timeout up to 255)
    localparam int FLUSH_W = 4;   // flush counter (up to 15 cycles)

    // Load in EX writes a register that the ID instruction reads; x0 never hazards.
    function automatic logic load_use(
        input logic       id_valid,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2,
        input logic       mem_read,
        input logic [4:0] rd
    );
        return id_valid && mem_read && (rd != 5'd0) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones and clears on request.
module sat_counter
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Clear beats increment; saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stalls, mispredict
// flushes and data-memory wait handling, with stall/flush perf counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_resolved,
    input  logic             ex_mispredict,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_W:0]    TMO_LIM  = (WAIT_W+1)'(MEM_TIMEOUT);
    localparam logic [FLUSH_W-1:0] FL_START = FLUSH_W'(FLUSH_CYCLES - 1);

    hz_state_e          cur_st, nxt_st, eval_st;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [WAIT_W:0]    wait_inc;
    logic [FLUSH_W-1:0] fl_cnt, fl_nxt;
    logic               mw, mispred, lu, tmo_set, mispred_evt;

    assign mw       = mem_req & ~mem_ready;
    assign mispred  = ex_branch_resolved & ex_mispredict;
    assign lu       = load_use(id_valid, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd);
    assign wait_inc = {1'b0, wait_cnt} + (WAIT_W+1)'(1);
    assign state    = cur_st;

    // Mealy outputs and next state; while in reset, hazards are judged as in RUN.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_hold = 1'b0;
        nxt_st      = cur_st;
        wait_nxt    = wait_cnt;
        fl_nxt      = fl_cnt;
        tmo_set     = 1'b0;
        mispred_evt = 1'b0;
        eval_st     = rst_n ? cur_st : ST_RUN;
        case (eval_st)
            ST_RUN, ST_MEM_WAIT: begin
                if (mw) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                    if (eval_st == ST_RUN) begin
                        nxt_st   = ST_MEM_WAIT;
                        wait_nxt = '0;
                    end else if (wait_inc >= TMO_LIM) begin
                        // Give up on the memory: flag it and fall back to RUN.
                        tmo_set  = 1'b1;
                        nxt_st   = ST_RUN;
                        wait_nxt = '0;
                    end else begin
                        nxt_st   = ST_MEM_WAIT;
                        wait_nxt = wait_inc[WAIT_W-1:0];
                    end
                end else if (mispred) begin
                    // Mispredict wins over a load-use stall: the stalled op is wrong-path.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    mispred_evt = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        nxt_st = ST_FLUSH;
                        fl_nxt = FL_START;
                    end else begin
                        nxt_st = ST_RUN;
                    end
                end else begin
                    if (lu) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                    nxt_st = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // New mispredicts and load-use are wrong-path here and ignored.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (mw) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                end else if (fl_cnt <= FLUSH_W'(1)) begin
                    fl_nxt = '0;
                    nxt_st = ST_RUN;
                end else begin
                    fl_nxt = fl_cnt - FLUSH_W'(1);
                end
            end
            default: nxt_st = ST_RUN;
        endcase
    end

    // FSM state, wait/flush counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st      <= ST_RUN;
            wait_cnt    <= '0;
            fl_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            cur_st   <= nxt_st;
            wait_cnt <= wait_nxt;
            fl_cnt   <= fl_nxt;
            if (tmo_set)
                mem_timeout <= 1'b1;
        end
    end

    sat_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (~pc_write),
        .cnt   (stall_cnt)
    );

    sat_counter u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (mispred_evt),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs2, ex_mem_read;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_branch_resolved, ex_mispredict, mem_req, mem_ready, perf_clr;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .id_valid           (id_valid),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_uses_rs2        (id_uses_rs2),
        .ex_mem_read        (ex_mem_read),
        .ex_rd              (ex_rd),
        .ex_branch_resolved (ex_branch_resolved),
        .ex_mispredict      (ex_mispredict),
        .mem_req            (mem_req),
        .mem_ready          (mem_ready),
        .perf_clr           (perf_clr),
        .pc_write           (pc_write),
        .if_id_write        (if_id_write),
        .if_id_flush        (if_id_flush),
        .id_ex_flush        (id_ex_flush),
        .ex_mem_hold        (ex_mem_hold),
        .state              (state),
        .mem_timeout        (mem_timeout),
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt)
    );

    // {id_valid, rs1, rs2, uses_rs2, mem_read, rd, br_res, mispred, mem_req, mem_ready,
    //  expected {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold}, expected next state}
    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       mp;
        logic       mq;
        logic       mrdy;
        logic [4:0] exp_o;
        logic [1:0] exp_s;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [4:0] outs();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_rd = 0; ex_branch_resolved = 0; ex_mispredict = 0;
        mem_req = 0; mem_ready = 0; perf_clr = 0;
    endtask

    task automatic set_lu();
        id_valid = 1; id_rs1 = 5; ex_mem_read = 1; ex_rd = 5;
    endtask

    task automatic set_mp();
        ex_branch_resolved = 1; ex_mispredict = 1;
    endtask

    initial begin
        tbl[0]  = '{0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'b11000, 2'd0}; // idle
        tbl[1]  = '{1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, 5'b00010, 2'd0}; // LU on rs1
        tbl[2]  = '{1, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 0, 5'b11000, 2'd0}; // x0 load
        tbl[3]  = '{1, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, 5'b00010, 2'd0}; // LU on rs2
        tbl[4]  = '{1, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0, 0, 5'b11000, 2'd0}; // rs2 unused
        tbl[5]  = '{0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, 5'b11000, 2'd0}; // ID bubble
        tbl[6]  = '{1, 5'd5, 5'd0, 0, 0, 5'd5, 0, 0, 0, 0, 5'b11000, 2'd0}; // not a load
        tbl[7]  = '{0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0, 5'b11110, 2'd2}; // mispredict
        tbl[8]  = '{0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 5'b11000, 2'd0}; // correct predict
        tbl[9]  = '{0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b11000, 2'd0}; // unresolved
        tbl[10] = '{1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0, 0, 5'b11110, 2'd2}; // mispredict + LU
        tbl[11] = '{0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 5'b00001, 2'd1}; // mem wait
        tbl[12] = '{1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 1, 0, 5'b00001, 2'd1}; // MW beats all
        tbl[13] = '{1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 1, 1, 5'b00010, 2'd0}; // ready + LU
        tbl[14] = '{1, 5'd9, 5'd9, 1, 1, 5'd9, 0, 0, 0, 1, 5'b00010, 2'd0}; // both srcs

        set_idle();
        rst_n = 0;
        step(); step();
        rst_n = 1;

        // Reset state
        check("rst_state", state, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_timeout", mem_timeout, 0);
        @(negedge clk);
        check("rst_outs", outs(), 5'b11000);

        // Single-cycle load-use stall
        step();
        set_lu();
        @(negedge clk);
        check("lu_outs", outs(), 5'b00010);
        step();
        set_idle();
        check("lu_state", state, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        @(negedge clk);
        check("lu_release_outs", outs(), 5'b11000);

        // Mispredict: two flushing cycles, new hazards ignored in FLUSH
        step();
        set_mp();
        @(negedge clk);
        check("mp_outs", outs(), 5'b11110);
        step();
        set_lu(); set_mp();
        check("mp_state_flush", state, 2);
        check("mp_flush_cnt", flush_cnt, 1);
        @(negedge clk);
        check("flush_ignore_outs", outs(), 5'b11110);
        step();
        set_idle();
        check("flush_back_run", state, 0);
        check("flush_cnt_once", flush_cnt, 1);
        @(negedge clk);
        check("flush_done_outs", outs(), 5'b11000);

        // Memory wait of three cycles, then release
        step();
        mem_req = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mw_hold_outs", outs(), 5'b00001);
            check("mw_state", state, (k == 0) ? 0 : 1);
            step();
        end
        mem_ready = 1;
        @(negedge clk);
        check("mw_release_outs", outs(), 5'b11000);
        check("mw_release_state", state, 1);
        step();
        set_idle();
        check("mw_done_state", state, 0);
        check("mw_stall_cnt", stall_cnt, 4);

        // perf_clr beats a same-cycle stall increment
        set_lu();
        perf_clr = 1;
        step();
        set_idle();
        check("clr_stall_cnt", stall_cnt, 0);
        check("clr_flush_cnt", flush_cnt, 0);

        // Memory timeout: never ready
        mem_req = 1;
        repeat (4) step();
        check("tmo_pre_state", state, 1);
        check("tmo_pre_flag", mem_timeout, 0);
        step();
        set_idle();
        check("tmo_state", state, 0);
        check("tmo_flag", mem_timeout, 1);
        step();
        check("tmo_sticky", mem_timeout, 1);
        check("tmo_stall_cnt", stall_cnt, 5);

        // Memory wait while flushing freezes the flush counter
        set_mp();
        step();
        set_idle();
        mem_req = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("fmw_outs", outs(), 5'b00111);
            step();
            check("fmw_state", state, 2);
        end
        mem_req = 0;
        @(negedge clk);
        check("fmw_release_outs", outs(), 5'b11110);
        step();
        check("fmw_done_state", state, 0);
        check("fmw_stall_cnt", stall_cnt, 7);

        // Reset in the middle of FLUSH; hazards still judged while in reset
        set_mp();
        step();
        set_idle();
        check("rf_state_flush", state, 2);
        rst_n = 0;
        set_lu();
        @(negedge clk);
        check("rf_rst_outs", outs(), 5'b00010);
        step();
        rst_n = 1;
        set_idle();
        check("rf_state", state, 0);
        check("rf_stall_cnt", stall_cnt, 0);
        check("rf_flush_cnt", flush_cnt, 0);
        check("rf_timeout", mem_timeout, 0);

        // Table of single-cycle vectors from RUN, reset between each
        for (int i = 0; i < 15; i++) begin
            id_valid = tbl[i].v; id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
            id_uses_rs2 = tbl[i].u; ex_mem_read = tbl[i].mr; ex_rd = tbl[i].rd;
            ex_branch_resolved = tbl[i].br; ex_mispredict = tbl[i].mp;
            mem_req = tbl[i].mq; mem_ready = tbl[i].mrdy;
            @(negedge clk);
            check($sformatf("vec%0d_outs", i), outs(), tbl[i].exp_o);
            step();
            check($sformatf("vec%0d_next", i), state, tbl[i].exp_s);
            set_idle();
            rst_n = 0;
            step();
            rst_n = 1;
        end

        // Stall counter saturation
        set_lu();
        repeat (65540) step();
        check("sat_stall_cnt", stall_cnt, 16'hFFFF);
        step();
        check("sat_stall_hold", stall_cnt, 16'hFFFF);
        check("sat_flush_cnt", flush_cnt, 0);
        set_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
